// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if
//   Bundles the signals between the PLL lock sequencer and the PLL/core side.
//   master : used by the sequencer. It receives LOCK and the control requests
//            and drives the PLL controls and the status outputs.
//   slave  : used by the environment. It drives LOCK and the requests and
//            observes the sequencer outputs.
//   Signals:
//     PLL_LOCK          raw PLL LOCK (asynchronous to REFERENCECLK)
//     BYPASS_REQ        request to run with the PLL bypassed
//     DELAY_SET[3:0]    fine-delay value to load
//     DELAY_LOAD        one-cycle strobe that loads DELAY_SET
//     PLL_RESET         PLL RESET, active-high
//     PLL_BYPASS        PLL BYPASS
//     PLL_DYNAMICDELAY  PLL DYNAMICDELAY[3:0]
//     RST_OUT           active-high reset for the PLLOUT domain
//     READY             output clock usable
//     FAULT             sticky lock failure
//     RETRIES[2:0]      failed attempts since last RUN/BYP/RESET
//     STATE[2:0]        sequencer state code
interface pll_lock_sequencer_if;
    logic       PLL_LOCK;
    logic       BYPASS_REQ;
    logic [3:0] DELAY_SET;
    logic       DELAY_LOAD;
    logic       PLL_RESET;
    logic       PLL_BYPASS;
    logic [3:0] PLL_DYNAMICDELAY;
    logic       RST_OUT;
    logic       READY;
    logic       FAULT;
    logic [2:0] RETRIES;
    logic [2:0] STATE;

    modport master (
        input  PLL_LOCK, BYPASS_REQ, DELAY_SET, DELAY_LOAD,
        output PLL_RESET, PLL_BYPASS, PLL_DYNAMICDELAY,
               RST_OUT, READY, FAULT, RETRIES, STATE
    );

    modport slave (
        output PLL_LOCK, BYPASS_REQ, DELAY_SET, DELAY_LOAD,
        input  PLL_RESET, PLL_BYPASS, PLL_DYNAMICDELAY,
               RST_OUT, READY, FAULT, RETRIES, STATE
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Core-side controller for the iCE40UP system PLL. It holds the PLL in
//   reset, releases it, qualifies LOCK for stability, and then releases the
//   downstream domain reset and raises READY. A lock timeout retries the
//   attempt; after MAX_RETRIES consecutive failures FAULT latches until
//   RESET. A bypass mode runs the downstream domain from the bypass clock.
//   Ports:
//     REFERENCECLK  free-running PLL reference clock (sole clock)
//     RESET         synchronous, active-high reset
//     bus           pll_lock_sequencer_if.master (PLL controls and status)
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES        = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter logic [3:0]  DELAY_INIT          = 4'b0000
) (
    input  logic                        REFERENCECLK,
    input  logic                        RESET,
    pll_lock_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_BYP    = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // Counters are compared against "last" values so that each phase lasts
    // exactly N edges counted from the edge that entered it.
    localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] STB_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        lock_meta_q, lock_s_q;
    logic        pll_reset_q, pll_reset_d;
    logic        pll_bypass_q, pll_bypass_d;
    logic [3:0]  delay_q, delay_d;
    logic        rst_out_q, rst_out_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic [2:0]  retries_q, retries_d;
    logic [2:0]  retries_inc;
    logic        timeout;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge REFERENCECLK) begin
        if (RESET) begin
            state_q      <= ST_RST;
            cnt_q        <= '0;
            tmo_q        <= '0;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            pll_reset_q  <= 1'b1;
            pll_bypass_q <= 1'b0;
            delay_q      <= DELAY_INIT;
            rst_out_q    <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            retries_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            lock_meta_q  <= bus.PLL_LOCK;
            lock_s_q     <= lock_meta_q;
            pll_reset_q  <= pll_reset_d;
            pll_bypass_q <= pll_bypass_d;
            delay_q      <= delay_d;
            rst_out_q    <= rst_out_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            retries_q    <= retries_d;
        end
    end

    assign timeout     = (tmo_q == TMO_LAST);
    assign retries_inc = retries_q + 3'd1;

    // NOTE: every variable driven here gets a hold default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        pll_reset_d  = pll_reset_q;
        pll_bypass_d = pll_bypass_q;
        delay_d      = delay_q;
        rst_out_d    = rst_out_q;
        ready_d      = ready_q;
        fault_d      = fault_q;
        retries_d    = retries_q;

        if (state_q != ST_FAULT && bus.DELAY_LOAD) begin
            delay_d = bus.DELAY_SET;
        end

        if (state_q == ST_FAULT) begin
            // Sticky until RESET; bypass requests are ignored here.
            pll_reset_d = 1'b1;
            rst_out_d   = 1'b1;
            ready_d     = 1'b0;
            fault_d     = 1'b1;
        end else if (bus.BYPASS_REQ && state_q != ST_BYP) begin
            state_d      = ST_BYP;
            cnt_d        = '0;
            pll_bypass_d = 1'b1;
            pll_reset_d  = 1'b1;
            rst_out_d    = 1'b1;
            ready_d      = 1'b0;
            retries_d    = '0;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d     = ST_WAIT;
                        cnt_d       = '0;
                        tmo_d       = '0;
                        pll_reset_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end

                ST_WAIT, ST_STABLE: begin
                    tmo_d = tmo_q + 16'd1;
                    // Stable completion is checked ahead of the timeout so a
                    // lock that qualifies on the final cycle still wins.
                    if (lock_s_q && ((state_q == ST_STABLE && cnt_q == STB_LAST) ||
                                     (state_q == ST_WAIT && STB_LAST == 16'd0))) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        rst_out_d = 1'b0;
                        ready_d   = 1'b1;
                        retries_d = '0;
                    end else if (timeout) begin
                        retries_d   = retries_inc;
                        pll_reset_d = 1'b1;
                        cnt_d       = '0;
                        if (retries_inc == RETRY_MAX) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = ST_RST;
                        end
                    end else if (lock_s_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = (state_q == ST_WAIT) ? 16'd1 : cnt_q + 16'd1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end

                ST_RUN: begin
                    // Loss of lock restarts the sequence without counting
                    // as a failed attempt.
                    if (!lock_s_q) begin
                        state_d     = ST_RST;
                        cnt_d       = '0;
                        pll_reset_d = 1'b1;
                        rst_out_d   = 1'b1;
                        ready_d     = 1'b0;
                    end
                end

                ST_BYP: begin
                    if (!bus.BYPASS_REQ) begin
                        state_d      = ST_RST;
                        cnt_d        = '0;
                        pll_bypass_d = 1'b0;
                        pll_reset_d  = 1'b1;
                        rst_out_d    = 1'b1;
                        ready_d      = 1'b0;
                    end else if (rst_out_q) begin
                        // Hold the domain reset for RESET_CYCLES after entry,
                        // then stop counting.
                        if (cnt_q == RST_LAST) begin
                            rst_out_d = 1'b0;
                            ready_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end

                default: begin
                    state_d     = ST_RST;
                    cnt_d       = '0;
                    pll_reset_d = 1'b1;
                    rst_out_d   = 1'b1;
                    ready_d     = 1'b0;
                end
            endcase
        end
    end

    assign bus.PLL_RESET        = pll_reset_q;
    assign bus.PLL_BYPASS       = pll_bypass_q;
    assign bus.PLL_DYNAMICDELAY = delay_q;
    assign bus.RST_OUT          = rst_out_q;
    assign bus.READY            = ready_q;
    assign bus.FAULT            = fault_q;
    assign bus.RETRIES          = retries_q;
    assign bus.STATE            = state_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Core-side controller for the iCE40UP system PLL: drives the PLL's RESET, BYPASS and DYNAMICDELAY inputs and consumes its LOCK output. It sequences PLL reset release, qualifies LOCK for stability, and generates the downstream domain reset and ready flag. It retries on lock timeout and latches a fault after repeated failure. It runs on the free-running reference clock that also feeds the PLL.

## Interface
- RESET_CYCLES, 16: cycles PLL_RESET is held high per attempt (1..65535).
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-LOCK-high cycles required before release (1..65535).
- LOCK_TIMEOUT_CYCLES, 4096: cycles allowed from PLL_RESET release to RUN (must be greater than LOCK_STABLE_CYCLES, at most 65535).
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (1..7).
- DELAY_INIT, 4'b0000: reset value of PLL_DYNAMICDELAY.
- REFERENCECLK  in  1  sole clock; free-running PLL reference.
- RESET  in  1  synchronous, active-high reset.
- PLL_LOCK  in  1  LOCK from the PLL; asynchronous, passed through a 2-flop synchronizer (lock_s).
- BYPASS_REQ  in  1  synchronous request to run with the PLL bypassed.
- DELAY_SET  in  4  new fine-delay value.
- DELAY_LOAD  in  1  one-cycle strobe; loads DELAY_SET.
- PLL_RESET  out  1  to PLL RESET, active-high.
- PLL_BYPASS  out  1  to PLL BYPASS.
- PLL_DYNAMICDELAY  out  4  to PLL DYNAMICDELAY.
- RST_OUT  out  1  active-high reset for the PLLOUT domain.
- READY  out  1  PLLOUT (or bypass clock) usable.
- FAULT  out  1  sticky lock failure.
- RETRIES  out  3  failed attempts since the last RUN, BYPASS or RESET.
- STATE  out  3  0 RST, 1 WAIT, 2 STABLE, 3 RUN, 4 BYP, 5 FAULT.

## Operation
- All outputs are registered. One 16-bit phase counter (cnt) and one 16-bit timeout counter (tmo) are used.
- RST: PLL_RESET=1, RST_OUT=1, READY=0. cnt counts up to RESET_CYCLES. Then go to WAIT with PLL_RESET=0, tmo=0.
- WAIT: tmo increments each cycle. When lock_s=1, go to STABLE with cnt=1.
- STABLE: tmo keeps incrementing. While lock_s=1, cnt increments. When cnt reaches LOCK_STABLE_CYCLES, go to RUN: RST_OUT=0, READY=1, RETRIES=0. If lock_s=0, go to WAIT and clear cnt.
- Timeout: if tmo reaches LOCK_TIMEOUT_CYCLES in WAIT or STABLE, RETRIES increments.
  - If the new RETRIES equals MAX_RETRIES, go to FAULT.
  - Otherwise go to RST with cnt=0.
  - If stable completion and timeout occur on the same cycle, stable completion wins.
- RUN: if lock_s=0, then on the same edge RST_OUT=1, READY=0, go to RST. This does not increment RETRIES.
- FAULT: PLL_RESET=1, RST_OUT=1, READY=0, FAULT=1. Exit only via RESET. BYPASS_REQ is ignored.
- BYPASS_REQ=1 in any state except FAULT moves to BYP next edge.
  - In BYP: PLL_BYPASS=1, PLL_RESET=1, RETRIES=0.
  - RST_OUT=1 for RESET_CYCLES cycles after entry, then RST_OUT=0 and READY=1.
  - BYPASS_REQ=0 in BYP moves to RST next edge: PLL_BYPASS=0, RST_OUT=1, READY=0.
- Priority: RESET > FAULT hold > BYPASS_REQ > lock and timeout events.
- DELAY_LOAD (not in FAULT) loads PLL_DYNAMICDELAY from DELAY_SET on the next edge. It works in every other state and causes no state change. In FAULT the strobe is ignored.

## Timing
- Reset values: PLL_RESET=1, PLL_BYPASS=0, PLL_DYNAMICDELAY=DELAY_INIT, RST_OUT=1, READY=0, FAULT=0, RETRIES=0, STATE=0, cnt=tmo=0, synchronizer flops=0.
- Counting starts on the first edge after RESET falls. PLL_RESET is high for exactly RESET_CYCLES edges, then falls.
- LOCK-to-lock_s latency is 2 cycles.
- RST_OUT falls LOCK_STABLE_CYCLES cycles after lock_s first rises, giving 2+LOCK_STABLE_CYCLES cycles from PLL_LOCK.
- Loss of lock in RUN reaches RST_OUT 3 cycles after PLL_LOCK falls (2 synchronizer cycles plus 1 registered-output cycle).
- The timeout fires on the edge where tmo equals LOCK_TIMEOUT_CYCLES.
- A RESET asserted mid-sequence takes effect on the next edge and overrides all other events.
- READY and RST_OUT are never both 1.

## Test plan
Common parameters: RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2.
- Clean lock: release RESET; PLL_LOCK rises 10 cycles after PLL_RESET falls and stays high -> PLL_RESET high for 4 cycles; RST_OUT falls and READY rises exactly 10 cycles after PLL_LOCK rises; STATE=3; RETRIES=0.
- Chattering lock: PLL_LOCK high for 5 cycles, low for 1, then steady high -> STATE returns to 1 and then to 2; RUN is reached 8 cycles after lock_s rises the second time.
- Timeout and fault: PLL_LOCK held at 0 -> RETRIES=1 after 64 WAIT cycles; PLL_RESET pulses for 4 cycles again; after the second timeout FAULT=1, STATE=5, PLL_RESET=1; BYPASS_REQ=1 has no effect; RESET clears everything.
- Lock loss in RUN: after RUN, drop PLL_LOCK -> RST_OUT=1 and READY=0 3 cycles later; STATE=0; RETRIES stays 0; relock completes a normal sequence.
- Bypass: assert BYPASS_REQ during WAIT -> PLL_BYPASS=1 and PLL_RESET=1 next edge; RST_OUT falls and READY rises 4 cycles later; deassert BYPASS_REQ -> STATE=0, PLL_BYPASS=0, full lock sequence reruns.
- Delay load: DELAY_SET=4'hA with DELAY_LOAD during RUN -> PLL_DYNAMICDELAY=4'hA next edge; STATE stays 3; the same load attempted in FAULT leaves the value unchanged.
